// File: rtl/pll.sv
// Behavioural NCO clock generator with a sticky lock indicator.
// Runs entirely in the clock_in domain.
module pll #(
    parameter int          ACC_W      = 16,
    parameter int unsigned FREQ_WORD  = 32768,
    parameter int          LOCK_EDGES = 4
) (
    input  logic clock_in,
    input  logic reset,
    output logic clock_out,
    output logic locked
);

    if (ACC_W < 4 || ACC_W > 32) begin : g_bad_acc_w
        $error("pll: ACC_W out of range 4..32");
    end

    if (FREQ_WORD < 1 ||
        longint'(FREQ_WORD) > (64'sd1 <<< (ACC_W - 1))) begin : g_bad_freq
        $error("pll: FREQ_WORD out of range 1..2^(ACC_W-1)");
    end

    if (LOCK_EDGES < 1 || LOCK_EDGES > 65535) begin : g_bad_lock
        $error("pll: LOCK_EDGES out of range 1..65535");
    end

    localparam logic [ACC_W-1:0] INC  = ACC_W'(FREQ_WORD);
    localparam logic [15:0]      LAST = 16'(LOCK_EDGES - 1);

    logic [ACC_W-1:0] acc;
    logic             prev_out;
    logic [15:0]      edge_cnt;
    logic             rise;

    assign clock_out = acc[ACC_W-1];
    assign rise      = clock_out & ~prev_out;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            acc      <= '0;
            prev_out <= 1'b0;
            edge_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            acc      <= acc + INC;
            prev_out <= clock_out;
            // counter parks at LAST once the lock edge is seen
            if (rise && !locked) begin
                if (edge_cnt == LAST) begin
                    locked <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll.sv
// Randomized-reset bench for pll against an arithmetic reference model.
// Four instances with different ratios share one clock and reset.
module tb_pll;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] co;
    logic [3:0] lk;

    always #5 clk = ~clk;

    pll #(.ACC_W(16), .FREQ_WORD(32768), .LOCK_EDGES(4)) u0 (
        .clock_in(clk), .reset(reset), .clock_out(co[0]), .locked(lk[0]));
    pll #(.ACC_W(16), .FREQ_WORD(16384), .LOCK_EDGES(4)) u1 (
        .clock_in(clk), .reset(reset), .clock_out(co[1]), .locked(lk[1]));
    pll #(.ACC_W(12), .FREQ_WORD(1365), .LOCK_EDGES(7)) u2 (
        .clock_in(clk), .reset(reset), .clock_out(co[2]), .locked(lk[2]));
    pll #(.ACC_W(4), .FREQ_WORD(5), .LOCK_EDGES(1)) u3 (
        .clock_in(clk), .reset(reset), .clock_out(co[3]), .locked(lk[3]));

    int     n_cmp = 0;
    int     n_err = 0;
    longint w_m[4]  = '{16, 16, 12, 4};
    longint fw_m[4] = '{32768, 16384, 1365, 5};
    int     le_m[4] = '{4, 4, 7, 1};

    longint n[4];
    int     rises[4];
    bit     exp_co[4];
    bit     exp_lk[4];

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // ideal NCO output after k free-running cycles
    function automatic bit nco(input int i, input longint k);
        longint m;
        m = 64'd1 << w_m[i];
        return ((k * fw_m[i]) % m) >= (m / 2);
    endfunction

    task automatic model_step(input bit r);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                n[i] = 0;
                rises[i] = 0;
            end else begin
                n[i]++;
                // lock reflects rises strictly before this edge
                exp_lk[i] = rises[i] >= le_m[i];
                if (nco(i, n[i]) && !nco(i, n[i] - 1))
                    rises[i]++;
            end
            if (r) exp_lk[i] = 1'b0;
            exp_co[i] = nco(i, n[i]);
        end
    endtask

    task automatic cycle(input bit r);
        reset = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clock_out%0d", i), co[i], exp_co[i]);
            check($sformatf("locked%0d", i), lk[i], exp_lk[i]);
        end
    endtask

    initial begin
        int hold;
        int first_lock;
        int frac_rises;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            n[i] = 0;
            rises[i] = 0;
            exp_co[i] = 0;
            exp_lk[i] = 0;
        end
        @(negedge clk);

        for (int c = 0; c < 5; c++) cycle(1'b1);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0 && $urandom_range(0, 199) == 0)
                hold = $urandom_range(1, 5);
            cycle(hold != 0);
            if (hold != 0) hold--;
        end

        for (int c = 0; c < 5; c++) cycle(1'b1);
        first_lock = -1;
        frac_rises = 0;
        for (int c = 1; c <= 12288; c++) begin
            bit prev2;
            prev2 = co[2];
            cycle(1'b0);
            if (first_lock < 0 && lk[0]) first_lock = c;
            if (co[2] && !prev2) frac_rises++;
        end
        check("lock_latency_default", first_lock, 8);
        ok = (frac_rises >= 4094) && (frac_rises <= 4096);
        check("frac_rise_count_ok", ok, 1);

        cycle(1'b1);
        check("midreset_locked", lk[0], 0);
        check("midreset_clock_out", co[0], 0);
        first_lock = -1;
        for (int c = 1; c <= 40000; c++) begin
            cycle(1'b0);
            if (first_lock < 0 && lk[0]) first_lock = c;
        end
        check("relock_latency_default", first_lock, 8);
        check("still_locked_u1", lk[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
